// File: rtl/bram_burst_reader_pkg.sv
// Shared types and constants for the BRAM burst reader.
// State encoding and output buffer sizing.
package bram_burst_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int RD_BUF_DEPTH = 2;
    localparam int RD_CNT_WIDTH = $clog2(RD_BUF_DEPTH + 1);

endpackage

// File: rtl/stream_skid_buf2.sv
// Two-entry FIFO holding stream words while the consumer stalls.
// Push and pop may happen on the same edge.
module stream_skid_buf2
    import bram_burst_reader_pkg::*;
#(
    parameter int WIDTH = 33
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        head,
    output logic                    valid,
    output logic [RD_CNT_WIDTH-1:0] count
);

    logic [WIDTH-1:0] mem [RD_BUF_DEPTH];
    logic             rd_ptr;
    logic             wr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + RD_CNT_WIDTH'(push) - RD_CNT_WIDTH'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign valid = (count != '0);

endmodule

// File: rtl/bram_burst_reader.sv
// Streams a burst of words out of a block-RAM read port.
// Credit-based issue keeps the 2-entry buffer from overflowing.
module bram_burst_reader
    import bram_burst_reader_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int COUNT_WIDTH = 11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_start,
    input  logic [ADDR_WIDTH-1:0]  i_base_addr,
    input  logic [COUNT_WIDTH-1:0] i_count,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [ADDR_WIDTH-1:0]  o_ram_addr,
    input  logic [DATA_WIDTH-1:0]  i_ram_dout,
    output logic [DATA_WIDTH-1:0]  o_data,
    output logic                   o_valid,
    output logic                   o_last,
    input  logic                   i_ready
);

    state_t                  state;
    state_t                  state_nxt;
    logic [COUNT_WIDTH-1:0]  issue_left;
    logic [COUNT_WIDTH-1:0]  issue_left_nxt;
    logic [ADDR_WIDTH-1:0]   addr_nxt;
    logic                    pend;
    logic                    pend_nxt;
    logic                    pend_last;
    logic                    pend_last_nxt;
    logic                    busy_nxt;
    logic                    done_nxt;

    logic [DATA_WIDTH:0]     buf_head;
    logic                    buf_valid;
    logic [RD_CNT_WIDTH-1:0] buf_cnt;
    logic                    pop;
    logic                    buf_last;
    logic [2:0]              credit;

    stream_skid_buf2 #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pend),
        .push_data ({pend_last, i_ram_dout}),
        .pop       (pop),
        .head      (buf_head),
        .valid     (buf_valid),
        .count     (buf_cnt)
    );

    assign pop      = buf_valid & i_ready;
    assign buf_last = buf_head[DATA_WIDTH];
    assign o_valid  = buf_valid;
    assign o_data   = buf_valid ? buf_head[DATA_WIDTH-1:0] : '0;
    assign o_last   = buf_valid & buf_last;

    // Occupancy the buffer will have after this edge, before any new issue.
    assign credit = 3'(buf_cnt) + 3'(pend) - 3'(pop);

    always_comb begin
        state_nxt      = state;
        issue_left_nxt = issue_left;
        addr_nxt       = o_ram_addr;
        pend_nxt       = 1'b0;
        pend_last_nxt  = 1'b0;
        busy_nxt       = o_busy;
        done_nxt       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_count != '0) begin
                        state_nxt      = ST_RUN;
                        issue_left_nxt = i_count;
                        addr_nxt       = i_base_addr;
                        busy_nxt       = 1'b1;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (credit < 3'(RD_BUF_DEPTH)) begin
                    addr_nxt       = o_ram_addr + ADDR_WIDTH'(1);
                    issue_left_nxt = issue_left - COUNT_WIDTH'(1);
                    pend_nxt       = 1'b1;
                    if (issue_left == COUNT_WIDTH'(1)) begin
                        pend_last_nxt = 1'b1;
                        state_nxt     = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && buf_last) begin
                    state_nxt = ST_IDLE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            issue_left <= '0;
            o_ram_addr <= '0;
            pend       <= 1'b0;
            pend_last  <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            state      <= state_nxt;
            issue_left <= issue_left_nxt;
            o_ram_addr <= addr_nxt;
            pend       <= pend_nxt;
            pend_last  <= pend_last_nxt;
            o_busy     <= busy_nxt;
            o_done     <= done_nxt;
        end
    end

endmodule
